hps_download_master: RTL
========================

// Module: hps_download_master
// PURPOSE
//  Simulation/bring-up stand-in for the ARM side of the HPS I/O bus: acts as the initiator that hps_io responds to.
//  On a start pulse it replays a complete MiSTer file download (index, TX start, data, TX end) as io_enable/io_strobe/io_din word traffic.
//  Data bytes are pulled from a byte source (ROM model/testbench memory) through a req/valid handshake; honours hps_io back-pressure via io_wait.
// PARAMETERS
//  WIDE   0   1: 16-bit data words (2 bytes/strobe, little-endian); 0: 8-bit data in io_din[7:0], io_din[15:8]=0
//  GAP    4   idle cycles with io_enable low between command frames (>=1)
//  LEN_W  27  width of length/src_addr
// PORTS
//  clk_sys    in   1      system clock, all logic rising-edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      1-cycle request to begin a download; ignored while busy
//  index      in   8      menu index sent with FILE_INDEX
//  length     in   LEN_W  byte count to send (0 allowed)
//  busy       out  1      high from cycle after accepted start until done
//  done       out  1      1-cycle pulse when TX-end frame completes
//  src_req    out  1      1-cycle byte fetch request
//  src_addr   out  LEN_W  byte address of fetch, 0..length-1
//  src_data   in   8      fetched byte, valid with src_valid
//  src_valid  in   1      1-cycle pulse, >=1 cycle after src_req
//  io_enable  out  1      command frame select
//  io_strobe  out  1      word strobe, 1 cycle wide
//  io_din     out  16     word to hps_io, valid in strobe cycle
//  io_wide    out  1      constant = WIDE
//  io_wait    in   1      hps_io back-pressure; no strobe while high
// BEHAVIOUR
//  Reset (async, immediate): io_enable=0, io_strobe=0, io_din=0, src_req=0, src_addr=0, busy=0, done=0, FSM=IDLE.
//  Frames, in order: F0 {0x0054, index}; F1 {0x0053, 0x00FF}; F2 {0x0055, data...} (omitted if length==0); F3 {0x0053, 0x0000}.
//  Frame timing: io_enable rises; first strobe no earlier than next cycle; every strobe exactly 1 cycle, followed by >=1 low cycle.
//  io_din changes only in strobe cycles and holds between strobes. io_enable falls the cycle after the frame's last strobe.
//  Then GAP cycles with io_enable=0 before next frame.
//  Strobe rule: strobe issues in cycle N only if io_wait sampled low in N and word is ready; else stall, io_enable stays high.
//  FSM: IDLE -(start)-> EN -> CMD -> LOW -> ARG -> (F2: FETCH<->ARG per word) -> CLOSE -> GAP -> next frame EN | DONE -> IDLE.
//  Data fetch: src_req pulses once per byte, src_addr increments 0..length-1; byte captured on src_valid.
//  WIDE=0: one byte per strobe. WIDE=1: word = {byte[2k+1], byte[2k]}; odd length -> last word {8'h00, last byte}, no extra fetch.
//  At most one fetch outstanding; next fetch may overlap previous strobe's low cycle.
//  length==0: F0, F1, F3 only; src_req never asserts.
//  done: pulse in cycle after F3's io_enable falls; busy falls same cycle; start accepted again from following cycle.
//  start while busy: ignored; no latch of index/length. index/length captured on accepted start only.
//  rst_n low mid-frame: io_enable drops asynchronously; no done pulse; restart requires new start.
// TESTING
//  WIDE=0, index=2, length=3, bytes A1,B2,C3 -> strobes 0054,0002 | 0053,00FF | 0055,00A1,00B2,00C3 | 0053,0000; one done; io_enable low >=GAP between frames.
//  WIDE=1, length=3, bytes 11,22,33 -> F2 data strobes 2211 then 0033; exactly 3 src_req, addrs 0,1,2.
//  io_wait held high 10 cycles before 2nd data strobe -> no strobe in those cycles, io_enable stays 1, io_din unchanged; resumes after.
//  src_valid latency 5 cycles -> strobe spacing stretches; data order and count exact.
//  length=0 -> frames F0,F1,F3 only; src_req never high; done pulses.
//  rst_n low during F2, then start with new index -> all outputs 0 during reset; full new sequence from F0; start during busy ignored.

Source files
------------

// File: rtl/hps_download_master.sv
// Stand-in for the ARM side of the HPS I/O bus. A start pulse makes it replay a
// complete MiSTer file download (FILE_INDEX, TX start, data, TX end) as
// io_enable/io_strobe/io_din traffic. Data bytes come from an external byte
// source through a src_req/src_valid handshake. io_wait from hps_io holds off
// strobes.
//
// Ports
//   clk_sys, rst_n      clock, asynchronous active-low reset
//   start               1-cycle download request (ignored while busy)
//   index, length       menu index / byte count, captured on accepted start
//   busy, done          in-progress flag, 1-cycle completion pulse
//   src_req, src_addr   byte fetch request and address (0..length-1)
//   src_data, src_valid fetched byte and its 1-cycle valid
//   io_enable           command frame select
//   io_strobe, io_din   word strobe and word
//   io_wide             constant, 1 when 16-bit data words are used
//   io_wait             hps_io back-pressure
module hps_download_master #(
    parameter int unsigned WIDE  = 0,
    parameter int unsigned GAP   = 4,
    parameter int unsigned LEN_W = 27
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       index,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic             src_req,
    output logic [LEN_W-1:0] src_addr,
    input  logic [7:0]       src_data,
    input  logic             src_valid,
    output logic             io_enable,
    output logic             io_strobe,
    output logic [15:0]      io_din,
    output logic             io_wide,
    input  logic             io_wait
);

    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [15:0] CMD_FILE_INDEX = 16'h0054;
    localparam logic [15:0] CMD_FILE_TX    = 16'h0053;
    localparam logic [15:0] CMD_FILE_DATA  = 16'h0055;

    // Frame numbers: 0 index, 1 TX start, 2 data, 3 TX end
    localparam logic [1:0] FR_INDEX = 2'd0;
    localparam logic [1:0] FR_TX_ON = 2'd1;
    localparam logic [1:0] FR_DATA  = 2'd2;
    localparam logic [1:0] FR_TX_OFF = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_EN,
        S_CMD,
        S_LOW,
        S_ARG,
        S_FETCH,
        S_CLOSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state;
    logic [1:0]         frame;
    logic [7:0]         index_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   ptr;
    logic [7:0]         lo_q;
    logic [7:0]         hi_q;
    logic               byte_sel;
    logic [GAP_W-1:0]   gap_cnt;

    logic [15:0]        cmd_word;
    logic [15:0]        arg_word;
    logic               more_bytes;

    assign io_wide    = (WIDE != 0);
    assign more_bytes = (ptr != len_q);

    // Command word and argument word of the current frame
    always_comb begin
        cmd_word = CMD_FILE_TX;
        arg_word = 16'h0000;
        case (frame)
            FR_INDEX: begin
                cmd_word = CMD_FILE_INDEX;
                arg_word = {8'h00, index_q};
            end
            FR_TX_ON: begin
                cmd_word = CMD_FILE_TX;
                arg_word = 16'h00FF;
            end
            FR_DATA: begin
                cmd_word = CMD_FILE_DATA;
                arg_word = {hi_q, lo_q};
            end
            default: begin
                cmd_word = CMD_FILE_TX;
                arg_word = 16'h0000;
            end
        endcase
    end

    // Download sequencer; all outputs registered
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            frame     <= FR_INDEX;
            index_q   <= 8'h00;
            len_q     <= '0;
            ptr       <= '0;
            lo_q      <= 8'h00;
            hi_q      <= 8'h00;
            byte_sel  <= 1'b0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            src_req   <= 1'b0;
            src_addr  <= '0;
            io_enable <= 1'b0;
            io_strobe <= 1'b0;
            io_din    <= 16'h0000;
        end else begin
            io_strobe <= 1'b0;
            src_req   <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        index_q <= index;
                        len_q   <= length;
                        ptr     <= '0;
                        frame   <= FR_INDEX;
                        busy    <= 1'b1;
                        state   <= S_EN;
                    end
                end
                S_EN: begin
                    io_enable <= 1'b1;
                    state     <= S_CMD;
                end
                S_CMD: begin
                    if (!io_wait) begin
                        io_strobe <= 1'b1;
                        io_din    <= cmd_word;
                        state     <= S_LOW;
                    end
                end
                S_LOW: begin
                    // In the data frame every low cycle starts the next fetch
                    if (frame == FR_DATA) begin
                        src_req  <= 1'b1;
                        src_addr <= ptr;
                        ptr      <= ptr + LEN_W'(1);
                        byte_sel <= 1'b0;
                        state    <= S_FETCH;
                    end else begin
                        state <= S_ARG;
                    end
                end
                S_FETCH: begin
                    if (src_valid) begin
                        if (!byte_sel) begin
                            lo_q <= src_data;
                            hi_q <= 8'h00;
                            // Wide mode pairs bytes; an odd tail stays zero-padded
                            if ((WIDE != 0) && more_bytes) begin
                                src_req  <= 1'b1;
                                src_addr <= ptr;
                                ptr      <= ptr + LEN_W'(1);
                                byte_sel <= 1'b1;
                            end else begin
                                state <= S_ARG;
                            end
                        end else begin
                            hi_q  <= src_data;
                            state <= S_ARG;
                        end
                    end
                end
                S_ARG: begin
                    if (!io_wait) begin
                        io_strobe <= 1'b1;
                        io_din    <= arg_word;
                        state     <= ((frame == FR_DATA) && more_bytes) ? S_LOW : S_CLOSE;
                    end
                end
                S_CLOSE: begin
                    io_enable <= 1'b0;
                    if (frame == FR_TX_OFF) begin
                        state <= S_DONE;
                    end else begin
                        // Empty file: skip the data frame entirely
                        frame   <= ((frame == FR_TX_ON) && (len_q == '0)) ? FR_TX_OFF
                                                                          : frame + 2'd1;
                        gap_cnt <= GAP_W'(GAP - 1);
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_EN;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
